// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the parametrised APB RAM bank.
package apb_ram_pkg;

  // Transfer FSM: IDLE waits for a setup phase, ACCESS runs the wait count.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Wait counter width; covers WAIT_STATES up to 15.
  localparam int CNT_W = 4;

  // Number of paddr bits below word granularity for a given data width.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_ram_bank_if.sv
// APB4 slave-side signal bundle used by apb_ram_bank.
interface apb_ram_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_mem.sv
// Single-port synchronous RAM: chip enable, byte-lane write enables and a
// registered read port. A read happens when ce is high with no byte enable.
// The read register is resettable and can be forced to zero (rd_clr) so an
// erroring read presents zero data; the array itself is never cleared.
module apb_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                rd_clr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) begin
          mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data register: holds its value until the next read or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DATA_W{1'b0}};
    end else if (rd_clr) begin
      rdata <= {DATA_W{1'b0}};
    end else if (ce && (be == {(DATA_W/8){1'b0}})) begin
      rdata <= mem_r[addr];
    end
  end
endmodule

// File: rtl/apb_ram_bank.sv
// Parametrised APB4 RAM slave with byte strobes, range error response,
// configurable wait states and abort on psel drop.
// Optional write protection of the low words is enabled by defining
// APB_RAM_WPROT_EN (adds wprot_lock input and WPROT_WORDS parameter).
module apb_ram_bank
  import apb_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
`ifdef APB_RAM_WPROT_EN
  ,
  parameter int WPROT_WORDS = 16
`endif
) (
  input logic           pclk,
  input logic           preset,
`ifdef APB_RAM_WPROT_EN
  input logic           wprot_lock,
`endif
  apb_ram_bank_if.slave bus
);
  localparam int OFF_W  = off_bits(DATA_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STRB_W = DATA_W / 8;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                write_r;
  logic [MEM_AW-1:0]   idx_r;
  logic [STRB_W-1:0]   strb_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                err_r;

  logic [IDX_W-1:0]    idx_s;
  logic                oor_s;
  logic                prot_s;
  logic                setup_s;
  logic                done_s;
  logic                rd_en_s;
  logic                rd_clr_s;
  logic [STRB_W-1:0]   be_s;
  logic [MEM_AW-1:0]   addr_s;
  logic [DATA_W-1:0]   rdata_s;

  // Sub-word address bits are don't-care; fold them away explicitly.
  logic unused_paddr_s;
  assign unused_paddr_s = ^bus.paddr;

  // Decode of the current bus phase and RAM control.
  always_comb begin
    idx_s   = bus.paddr[ADDR_W-1:OFF_W];
    oor_s   = (32'(idx_s) >= 32'(DEPTH));
`ifdef APB_RAM_WPROT_EN
    prot_s  = wprot_lock && bus.pwrite && (32'(idx_s) < 32'(WPROT_WORDS));
`else
    prot_s  = 1'b0;
`endif
    setup_s  = (state_r == IDLE) && bus.psel && !bus.penable;
    done_s   = (state_r == ACCESS) && bus.psel && bus.penable &&
               (cnt_r == {CNT_W{1'b0}});
    rd_en_s  = setup_s && !bus.pwrite && !oor_s;
    rd_clr_s = setup_s && !bus.pwrite && oor_s;
    if (done_s && write_r && !err_r) begin
      be_s = strb_r;
    end else begin
      be_s = {STRB_W{1'b0}};
    end
    // Reads are issued from the live address at setup; writes use the latch.
    if (setup_s) begin
      addr_s = idx_s[MEM_AW-1:0];
    end else begin
      addr_s = idx_r;
    end
  end

  // Transfer FSM: latch the setup phase, count wait states, close or abort.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      write_r <= 1'b0;
      idx_r   <= {MEM_AW{1'b0}};
      strb_r  <= {STRB_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            state_r <= ACCESS;
            cnt_r   <= CNT_W'(WAIT_STATES);
            write_r <= bus.pwrite;
            idx_r   <= idx_s[MEM_AW-1:0];
            strb_r  <= bus.pstrb;
            wdata_r <= bus.pwdata;
            err_r   <= oor_s || prot_s;
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            state_r <= IDLE;
          end else if (bus.penable) begin
            if (cnt_r == {CNT_W{1'b0}}) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  apb_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk    (pclk),
    .rst_n  (preset),
    .ce     (rd_en_s || (|be_s)),
    .rd_clr (rd_clr_s),
    .be     (be_s),
    .addr   (addr_s),
    .wdata  (wdata_r),
    .rdata  (rdata_s)
  );

  assign bus.pready  = done_s;
  assign bus.pslverr = done_s && err_r;
  assign bus.prdata  = rdata_s;
endmodule

// File: tb/tb_apb_ram_bank.sv
// Scoreboard bench for apb_ram_bank: instance 0 has no wait states,
// instance 1 has three. Expected responses come from a word/byte model.
module tb_apb_ram_bank;
  typedef struct packed {
    logic        err;
    logic        is_rd;
    logic [31:0] data;
    logic [31:0] mask;
    logic [3:0]  waits;
  } exp_t;

  logic pclk = 1'b0;
  logic preset = 1'b0;
`ifdef APB_RAM_WPROT_EN
  logic wprot_lock = 1'b0;
`endif

  logic        psel_v    [2];
  logic        penable_v [2];
  logic        pwrite_v  [2];
  logic [15:0] paddr_v   [2];
  logic [31:0] pwdata_v  [2];
  logic [3:0]  pstrb_v   [2];
  logic        pready_w  [2];
  logic        pslverr_w [2];
  logic [31:0] prdata_w  [2];

  int checks = 0;
  int errors = 0;
  int waits_seen [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] mdl [2][1024];
  logic [3:0]  bv  [2][1024];

  apb_ram_bank_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();
  apb_ram_bank_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();

  assign bus0.psel = psel_v[0];      assign bus1.psel = psel_v[1];
  assign bus0.penable = penable_v[0]; assign bus1.penable = penable_v[1];
  assign bus0.pwrite = pwrite_v[0];  assign bus1.pwrite = pwrite_v[1];
  assign bus0.paddr = paddr_v[0];    assign bus1.paddr = paddr_v[1];
  assign bus0.pwdata = pwdata_v[0];  assign bus1.pwdata = pwdata_v[1];
  assign bus0.pstrb = pstrb_v[0];    assign bus1.pstrb = pstrb_v[1];
  assign pready_w[0] = bus0.pready;  assign pready_w[1] = bus1.pready;
  assign pslverr_w[0] = bus0.pslverr; assign pslverr_w[1] = bus1.pslverr;
  assign prdata_w[0] = bus0.prdata;  assign prdata_w[1] = bus1.prdata;

  apb_ram_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(16), .WAIT_STATES(0)) u_dut0 (
    .pclk       (pclk),
    .preset     (preset),
`ifdef APB_RAM_WPROT_EN
    .wprot_lock (wprot_lock),
`endif
    .bus        (bus0)
  );

  apb_ram_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(16), .WAIT_STATES(3)) u_dut1 (
    .pclk       (pclk),
    .preset     (preset),
`ifdef APB_RAM_WPROT_EN
    .wprot_lock (wprot_lock),
`endif
    .bus        (bus1)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] mask = 32'hFFFF_FFFF);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %h expected %h (mask %h)", name, k, act, exp, mask);
    end
  endtask

  function automatic void qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  // Reference model: word = addr/4, range and protection rules, byte merge.
  function automatic exp_t predict(input int k, input bit wr, input logic [15:0] addr,
                                   input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int idx;
    idx = int'(addr) / 4;
    e.err = 1'b0; e.is_rd = !wr; e.data = 32'd0; e.mask = 32'd0;
    e.waits = (k == 0) ? 4'd0 : 4'd3;
    if (idx >= 1024) begin
      e.err = 1'b1;
      if (!wr) e.mask = 32'hFFFF_FFFF;
    end else if (wr) begin
`ifdef APB_RAM_WPROT_EN
      if (wprot_lock && idx < 16) e.err = 1'b1;
`endif
      if (!e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            mdl[k][idx][b*8 +: 8] = data[b*8 +: 8];
            bv[k][idx][b] = 1'b1;
          end
        end
      end
    end else begin
      e.data = mdl[k][idx];
      for (int b = 0; b < 4; b++) e.mask[b*8 +: 8] = {8{bv[k][idx][b]}};
    end
    return e;
  endfunction

  task automatic xfer(input int k, input bit wr, input logic [15:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd = 32'd0;
    qpush(k, predict(k, wr, addr, data, strb));
    @(posedge pclk); #1;
    psel_v[k] = 1'b1; penable_v[k] = 1'b0; pwrite_v[k] = wr;
    paddr_v[k] = addr; pwdata_v[k] = data; pstrb_v[k] = strb;
    @(posedge pclk); #1;
    penable_v[k] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge pclk);
      if (pready_w[k]) begin
        got = 1'b1;
        rd = prdata_w[k];
        break;
      end
    end
    check("handshake", k, {31'd0, got}, 32'd1);
    if (!got) qpop(k);
  endtask

  task automatic idle(input int k, input int n);
    @(posedge pclk); #1;
    psel_v[k] = 1'b0; penable_v[k] = 1'b0;
    repeat (n) @(posedge pclk);
  endtask

  // Monitor: compare every completed transfer against the scoreboard front.
  always @(negedge pclk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!(psel_v[k] && penable_v[k])) begin
        waits_seen[k] = 0;
        check("pready_outside_access", k, {31'd0, pready_w[k]}, 32'd0);
      end else if (qsize(k) == 0) begin
        check("pready_unexpected", k, {31'd0, pready_w[k]}, 32'd0);
      end else begin
        e = qfront(k);
        if (e.is_rd) check("prdata", k, prdata_w[k], e.data, e.mask);
        if (pready_w[k]) begin
          check("wait_count", k, 32'(waits_seen[k]), {28'd0, e.waits});
          check("pslverr", k, {31'd0, pslverr_w[k]}, {31'd0, e.err});
          qpop(k);
          waits_seen[k] = 0;
        end else begin
          waits_seen[k]++;
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    int k, prev, word;
    for (int d = 0; d < 2; d++) begin
      psel_v[d] = 1'b0; penable_v[d] = 1'b0; pwrite_v[d] = 1'b0;
      paddr_v[d] = 16'd0; pwdata_v[d] = 32'd0; pstrb_v[d] = 4'd0;
      waits_seen[d] = 0;
      for (int i = 0; i < 1024; i++) begin
        bv[d][i] = 4'd0; mdl[d][i] = 32'd0;
      end
    end

    repeat (3) @(posedge pclk); #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_pready", d, {31'd0, pready_w[d]}, 32'd0);
      check("reset_pslverr", d, {31'd0, pslverr_w[d]}, 32'd0);
      check("reset_prdata", d, prdata_w[d], 32'd0);
    end
    preset = 1'b1;

    // Zero-wait write/read, byte strobes, empty strobe, sub-word address bits.
    xfer(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, rd);
    xfer(0, 1'b0, 16'h0010, 32'd0, 4'hF, rd);
    check("deadbeef", 0, rd, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 16'h0020, 32'h1122_3344, 4'hF, rd);
    xfer(0, 1'b1, 16'h0020, 32'hAABB_CCDD, 4'h5, rd);
    xfer(0, 1'b0, 16'h0020, 32'd0, 4'hF, rd);
    check("strobe_merge", 0, rd, 32'h11BB_33DD);
    xfer(0, 1'b1, 16'h0020, 32'h0000_0000, 4'h0, rd);
    xfer(0, 1'b0, 16'h0023, 32'd0, 4'hF, rd);
    check("zero_strobe_lowbits", 0, rd, 32'h11BB_33DD);

    // Out of range: word 1024 aliases word 0 in the low bits but must not touch it.
    xfer(0, 1'b1, 16'h0000, 32'h5A5A_0001, 4'hF, rd);
    xfer(0, 1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF, rd);
    xfer(0, 1'b0, 16'h1000, 32'd0, 4'hF, rd);
    check("oor_rdata", 0, rd, 32'd0);
    xfer(0, 1'b0, 16'h0000, 32'd0, 4'hF, rd);
    check("oor_word0", 0, rd, 32'h5A5A_0001);

    // Access strobe without a setup phase is ignored.
    idle(0, 1);
    psel_v[0] = 1'b1; penable_v[0] = 1'b1;
    repeat (3) @(posedge pclk);
    idle(0, 1);

    // Three wait states, then abort of a write during its wait phase.
    xfer(1, 1'b1, 16'h0024, 32'h0102_0304, 4'hF, rd);
    xfer(1, 1'b0, 16'h0024, 32'd0, 4'hF, rd);
    check("ws3_read", 1, rd, 32'h0102_0304);
    @(posedge pclk); #1;
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
    paddr_v[1] = 16'h0024; pwdata_v[1] = 32'hFFFF_FFFF; pstrb_v[1] = 4'hF;
    @(posedge pclk); #1;
    penable_v[1] = 1'b1;
    @(posedge pclk); #1;
    psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    repeat (2) @(posedge pclk);
    xfer(1, 1'b0, 16'h0024, 32'd0, 4'hF, rd);
    check("abort_no_write", 1, rd, 32'h0102_0304);

    // Reset pulse in the middle of a read.
    xfer(1, 1'b1, 16'h0020, 32'hCAFE_F00D, 4'hF, rd);
    @(posedge pclk); #1;
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b0; paddr_v[1] = 16'h0020;
    @(posedge pclk); #1;
    penable_v[1] = 1'b1;
    @(negedge pclk);
    check("rd_first_access", 1, prdata_w[1], 32'hCAFE_F00D);
    #2;
    preset = 1'b0; psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    #1;
    check("midreset_pready", 1, {31'd0, pready_w[1]}, 32'd0);
    check("midreset_prdata", 1, prdata_w[1], 32'd0);
    @(posedge pclk); #1;
    preset = 1'b1;
    xfer(1, 1'b0, 16'h0020, 32'd0, 4'hF, rd);
    check("after_reset_read", 1, rd, 32'hCAFE_F00D);
    idle(1, 1);

`ifdef APB_RAM_WPROT_EN
    // Write protection of low words.
    wprot_lock = 1'b0;
    xfer(0, 1'b1, 16'h0004, 32'h55AA_55AA, 4'hF, rd);
    wprot_lock = 1'b1;
    xfer(0, 1'b1, 16'h0004, 32'h1234_5678, 4'hF, rd);
    xfer(0, 1'b0, 16'h0004, 32'd0, 4'hF, rd);
    check("wprot_blocked", 0, rd, 32'h55AA_55AA);
    wprot_lock = 1'b0;
    xfer(0, 1'b1, 16'h0004, 32'h1234_5678, 4'hF, rd);
    xfer(0, 1'b0, 16'h0004, 32'd0, 4'hF, rd);
    check("wprot_unlocked", 0, rd, 32'h1234_5678);
`endif

    // Randomised traffic on both instances.
    prev = 0;
    for (int i = 0; i < 240; i++) begin
      k = int'($urandom_range(0, 1));
      if (k != prev) idle(prev, 0);
      prev = k;
      word = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1024, 1100))
                                         : int'($urandom_range(0, 40));
`ifdef APB_RAM_WPROT_EN
      wprot_lock = 1'($urandom_range(0, 1));
`endif
      xfer(k, 1'($urandom_range(0, 1)), 16'(word * 4 + int'($urandom_range(0, 3))),
           $urandom, 4'($urandom), rd);
      if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(0, 2)));
    end
    idle(prev, 3);
    for (int d = 0; d < 2; d++) check("scoreboard_drained", d, 32'(qsize(d)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_ram_bank.md
Name: apb_ram_bank

Overview:
- Parametrised APB slave RAM, the next generation of the fixed 16-bit single-wait-setting RAM slave.
- Generalised in data width, depth and wait states.
- Adds APB4 byte strobes (pstrb), an address-range error response (pslverr), a registered prdata hold, and a clean abort when psel drops mid-transfer.
- Sits on the peripheral APB segment behind the decoder, which drives psel.

Parameters:
- DATA_W, 32: data width in bits; multiple of 8, range 8..64.
- DEPTH, 1024: number of DATA_W words; power of two not required.
- ADDR_W, 16: paddr width; byte address.
- WAIT_STATES, 0: extra access-phase cycles before pready; range 0..15.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  asynchronous, active-low reset.
- psel  in  1  slave select from decoder.
- penable  in  1  APB access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address; word index = paddr >> log2(DATA_W/8).
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  write byte enables; ignored on reads.
- prdata  out  DATA_W  read data; registered.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset (preset=0, asynchronous): state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0. RAM contents are not cleared.
- FSM states: IDLE, ACCESS.
- IDLE -> ACCESS when psel=1 and penable=0 (setup phase). On that edge:
  - latch pwrite, word index, pstrb, pwdata, range flag (word index >= DEPTH);
  - load counter=WAIT_STATES;
  - for an in-range read, issue the RAM read.
- IDLE with penable=1 and no prior setup: ignored; pready stays 0.
- ACCESS with psel=1, penable=1, counter!=0: decrement counter; pready=0.
- ACCESS with psel=1, penable=1, counter==0: pready=1 combinationally; next state IDLE.
  - In-range write: RAM bytes with pstrb[i]=1 are written at the closing edge; others are unchanged.
  - In-range read: prdata holds the RAM word, valid from the first ACCESS cycle and stable until the next read completes.
  - Out-of-range: pslverr=1; no RAM write; prdata=0 for reads.
- ACCESS with psel=0: abort to IDLE; no write; pready=0; prdata unchanged.
- Latency:
  - zero wait: setup T0, pready in T1 (2-cycle APB transfer);
  - general case: pready asserts WAIT_STATES cycles after the first access cycle.
- Back-to-back: a new setup is legal in the cycle after pready; IDLE accepts it immediately.
- Writes with pstrb=0 complete normally with no RAM change.
- Low paddr bits below word granularity are ignored; no alignment error.
- Read-after-write to the same word in consecutive transfers returns the new data, since the read is issued after the write edge.

Optional Feature:
- Macro APB_RAM_WPROT_EN. When defined:
  - adds input wprot_lock (1 bit) and parameter WPROT_WORDS (default 16);
  - a write to word index < WPROT_WORDS while wprot_lock=1 completes with pslverr=1 and no RAM change;
  - reads are unaffected.
- When not defined: no port, no parameter; all in-range writes succeed.

Decomposition:
- Package apb_ram_pkg: state enum (IDLE, ACCESS); constant holding the wait-counter width (4); function computing the byte-offset bit count from DATA_W.
- Sub-module apb_ram_mem: single-port synchronous RAM with chip enable, per-byte write enables and a registered read port; parametrised by DATA_W and DEPTH.
- FSM, counter and error logic stay in apb_ram_bank.

Test Plan:
- Zero wait, DATA_W=32. Write 0xDEADBEEF to paddr 0x0010 with pstrb=0xF, then read 0x0010 -> pready high in the 2nd cycle of each transfer; prdata=0xDEADBEEF; pslverr=0.
- Byte strobes. Word 0x0020 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5; read back -> 0x11BB33DD.
- WAIT_STATES=3. Read transfer -> pready low for exactly 3 access cycles, high on the 4th; prdata valid throughout the access phase.
- Out of range, DEPTH=1024. Write then read paddr 0x1000 (word 1024) -> pslverr=1 with pready; prdata=0; word 0 unchanged.
- Abort and reset. Deassert psel during a write's wait phase -> RAM unchanged, FSM returns to IDLE. Pulse preset low mid-read -> pready=0, prdata=0 immediately; the next transfer completes normally.
- APB_RAM_WPROT_EN, WPROT_WORDS=16. With wprot_lock=1, write paddr 0x0004 -> pslverr=1, data unchanged. With wprot_lock=0, the same write succeeds.
